// File: rtl/renderizador_texto.sv
// Two-stage text renderer: maps VGA pixel coordinates onto a 16-slot message buffer,
// fetches glyph rows from an external combinational font ROM and emits RGB with aligned syncs.
module renderizador_texto #(
  parameter logic [9:0]  ORIGEN_X     = 10'd256,
  parameter logic [9:0]  ORIGEN_Y     = 10'd232,
  parameter logic [11:0] COLOR_FG     = 12'hFFF,
  parameter logic [11:0] COLOR_BG     = 12'h000,
  parameter logic [7:0]  BLINK_FRAMES = 8'd30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [2:0]  wr_data,
  input  logic        cursor_en,
  input  logic [3:0]  cursor_pos,
  output logic [2:0]  direccion,
  output logic [3:0]  rom,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  typedef enum logic {VISIBLE = 1'b0, HIDDEN = 1'b1} blink_state_t;

  localparam logic [7:0] BLINK_LAST = BLINK_FRAMES - 8'd1;

  logic [2:0] buffer [16];

  // NOTE: the buffer is small enough to live in flops, so it is reset like any
  // other register; a RAM-mapped buffer would have to drop this reset loop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) buffer[i] <= '0;
    end else if (wr_en) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  logic [9:0] rel_x, rel_y;
  logic       in_win;
  logic [3:0] slot;
  logic       cur_hit;

  // The explicit >= guards stop the unsigned wrap of rel_x/rel_y from aliasing
  // pixels left of or above the window into it.
  always_comb begin
    rel_x   = pixel_x - ORIGEN_X;
    rel_y   = pixel_y - ORIGEN_Y;
    in_win  = (pixel_x >= ORIGEN_X) && (rel_x < 10'd128) &&
              (pixel_y >= ORIGEN_Y) && (rel_y < 10'd16);
    slot    = rel_x[6:3];
    cur_hit = cursor_en && in_win && (slot == cursor_pos) && (rel_y[3:1] == 3'b111);
  end

  logic [2:0] col_d1;
  logic       in_win_d1, video_on_d1, hsync_d1, vsync_d1, cur_hit_d1;

  // NOTE: every register below uses non-blocking assignments so each stage
  // samples the previous stage's value from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      direccion   <= '0;
      rom         <= '0;
      col_d1      <= '0;
      in_win_d1   <= 1'b0;
      video_on_d1 <= 1'b0;
      hsync_d1    <= 1'b1;
      vsync_d1    <= 1'b1;
      cur_hit_d1  <= 1'b0;
    end else begin
      direccion   <= in_win ? buffer[slot] : 3'd0;
      rom         <= in_win ? rel_y[3:0] : 4'd0;
      col_d1      <= rel_x[2:0];
      in_win_d1   <= in_win;
      video_on_d1 <= video_on;
      hsync_d1    <= hsync_in;
      vsync_d1    <= vsync_in;
      cur_hit_d1  <= cur_hit;
    end
  end

  blink_state_t state;
  logic [7:0]   frame_cnt;
  logic         vsync_prev;
  logic         vsync_fall;
  logic         blink_on;

  assign vsync_fall = vsync_prev && !vsync_in;
  assign blink_on   = (state == VISIBLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= VISIBLE;
      frame_cnt  <= '0;
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_fall) begin
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt <= '0;
          state     <= (state == VISIBLE) ? HIDDEN : VISIBLE;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  logic glyph_bit;
  logic pix;

  always_comb begin
    glyph_bit = rom_data[3'd7 - col_d1];
    pix       = in_win_d1 && (glyph_bit ^ (cur_hit_d1 && blink_on));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      if (!video_on_d1) rgb <= '0;
      else if (pix)     rgb <= COLOR_FG;
      else              rgb <= COLOR_BG;
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
    end
  end

endmodule

// File: tb/tb_renderizador_texto.sv
// Directed bench for renderizador_texto with a small behavioural font ROM.
module tb_renderizador_texto;

  logic        clk, reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [2:0]  wr_data;
  logic        cursor_en;
  logic [3:0]  cursor_pos;
  logic [2:0]  direccion;
  logic [3:0]  rom;
  logic [7:0]  rom_data;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int checks = 0;
  int failures = 0;

  renderizador_texto #(
    .ORIGEN_X(10'd256), .ORIGEN_Y(10'd232),
    .COLOR_FG(12'hFFF), .COLOR_BG(12'h000), .BLINK_FRAMES(8'd2)
  ) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_pos(cursor_pos),
    .direccion(direccion), .rom(rom), .rom_data(rom_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Font: space/blank are empty, J is 8'hFE on every row, others a row-dependent pattern.
  function automatic logic [7:0] font(input logic [2:0] code, input logic [3:0] row);
    case (code)
      3'd0, 3'd7: return 8'h00;
      3'd1:       return 8'hFE;
      default:    return 8'hA5 ^ {row, row};
    endcase
  endfunction

  assign rom_data = font(direccion, rom);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cursor_en = 1'b0; cursor_pos = '0;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (rgb !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle rgb=%h hs=%b vs=%b expected 000 1 1", rgb, hsync_out, vsync_out);
    end
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 3'd1;
    step();
    wr_en = 1'b0;
    pixel_x = 10'd256; pixel_y = 10'd234; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    step(); step();
    checks++;
    if (rgb !== 12'hFFF || hsync_out !== 1'b0 || direccion !== 3'd1) begin
      failures++;
      $display("FAIL reset_preload rgb=%h hs=%b dir=%0d expected FFF 0 1", rgb, hsync_out, direccion);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rgb !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1 ||
        direccion !== 3'd0 || rom !== 4'd0) begin
      failures++;
      $display("FAIL reset_async rgb=%h hs=%b vs=%b dir=%0d rom=%0d expected 000 1 1 0 0",
               rgb, hsync_out, vsync_out, direccion, rom);
    end
    hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_glyph();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 3'd1;
    step();
    wr_en = 1'b0;
    pixel_x = 10'd256; pixel_y = 10'd234; video_on = 1'b1;
    step();
    checks++;
    if (direccion !== 3'd1 || rom !== 4'd2) begin
      failures++;
      $display("FAIL glyph_rom_addr dir=%0d rom=%0d expected 1 2", direccion, rom);
    end
    step();
    checks++;
    if (rgb !== 12'hFFF) begin
      failures++;
      $display("FAIL glyph_col0 rgb=%h expected FFF", rgb);
    end
    pixel_x = 10'd263;
    step(); step();
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL glyph_col7 rgb=%h expected 000", rgb);
    end
  endtask

  task automatic test_window_edges();
    pixel_x = 10'd383; pixel_y = 10'd234;
    step();
    checks++;
    if (rom !== 4'd2 || direccion !== 3'd0) begin
      failures++;
      $display("FAIL win_last_col rom=%0d dir=%0d expected 2 0", rom, direccion);
    end
    pixel_x = 10'd384;
    step();
    checks++;
    if (rom !== 4'd0) begin
      failures++;
      $display("FAIL win_past_col rom=%0d expected 0", rom);
    end
    pixel_x = 10'd255;
    step();
    checks++;
    if (rom !== 4'd0 || direccion !== 3'd0) begin
      failures++;
      $display("FAIL win_left rom=%0d dir=%0d expected 0 0", rom, direccion);
    end
    step();
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL win_left_rgb rgb=%h expected 000", rgb);
    end
    pixel_x = 10'd256; pixel_y = 10'd247;
    step();
    checks++;
    if (rom !== 4'd15 || direccion !== 3'd1) begin
      failures++;
      $display("FAIL win_last_row rom=%0d dir=%0d expected 15 1", rom, direccion);
    end
    pixel_y = 10'd248;
    step();
    checks++;
    if (rom !== 4'd0 || direccion !== 3'd0) begin
      failures++;
      $display("FAIL win_past_row rom=%0d dir=%0d expected 0 0", rom, direccion);
    end
    pixel_y = 10'd231;
    step();
    checks++;
    if (rom !== 4'd0 || direccion !== 3'd0) begin
      failures++;
      $display("FAIL win_above rom=%0d dir=%0d expected 0 0", rom, direccion);
    end
  endtask

  task automatic test_blanking();
    pixel_x = 10'd256; pixel_y = 10'd234; video_on = 1'b0;
    step(); step();
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL blank_set_pixel rgb=%h expected 000", rgb);
    end
    video_on = 1'b1;
  endtask

  task automatic test_sync();
    hsync_in = 1'b0;
    step();
    hsync_in = 1'b1;
    checks++;
    if (hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL sync_t1 hs=%b expected 1", hsync_out);
    end
    step();
    checks++;
    if (hsync_out !== 1'b0) begin
      failures++;
      $display("FAIL sync_t2 hs=%b expected 0", hsync_out);
    end
    step();
    checks++;
    if (hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL sync_t3 hs=%b expected 1", hsync_out);
    end
  endtask

  task automatic test_back_to_back();
    pixel_y = 10'd234;
    for (int i = 0; i < 9; i++) begin
      pixel_x = (i < 8) ? 10'd256 + 10'(i) : 10'd0;
      step();
      if (i >= 1) begin
        checks++;
        if (rgb !== ((i - 1 < 7) ? 12'hFFF : 12'h000)) begin
          failures++;
          $display("FAIL stream_col%0d rgb=%h expected %h", i - 1, rgb,
                   (i - 1 < 7) ? 12'hFFF : 12'h000);
        end
      end
    end
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
  endtask

  task automatic test_cursor_blink();
    cursor_en = 1'b1; cursor_pos = 4'd3;
    pixel_x = 10'd280; pixel_y = 10'd246;
    step(); step();
    checks++;
    if (rgb !== 12'hFFF) begin
      failures++;
      $display("FAIL cursor_frame0 rgb=%h expected FFF", rgb);
    end
    pixel_y = 10'd245;
    step(); step();
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL cursor_row13 rgb=%h expected 000", rgb);
    end
    pixel_y = 10'd246;
    vsync_pulse();
    step();
    checks++;
    if (rgb !== 12'hFFF) begin
      failures++;
      $display("FAIL cursor_frame1 rgb=%h expected FFF", rgb);
    end
    vsync_pulse();
    step();
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL cursor_frame2 rgb=%h expected 000", rgb);
    end
    vsync_pulse();
    step();
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL cursor_frame3 rgb=%h expected 000", rgb);
    end
    vsync_pulse();
    step();
    checks++;
    if (rgb !== 12'hFFF) begin
      failures++;
      $display("FAIL cursor_frame4 rgb=%h expected FFF", rgb);
    end
    cursor_en = 1'b0;
    step(); step();
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL cursor_disabled rgb=%h expected 000", rgb);
    end
  endtask

  task automatic test_collision();
    pixel_x = 10'd296; pixel_y = 10'd232;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 3'd4;
    step();
    wr_en = 1'b0;
    checks++;
    if (direccion !== 3'd0) begin
      failures++;
      $display("FAIL collide_old dir=%0d expected 0", direccion);
    end
    step();
    checks++;
    if (direccion !== 3'd4) begin
      failures++;
      $display("FAIL collide_new dir=%0d expected 4", direccion);
    end
    step();
    checks++;
    if (rgb !== 12'hFFF) begin
      failures++;
      $display("FAIL collide_rgb rgb=%h expected FFF", rgb);
    end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_window_edges();
    test_blanking();
    test_sync();
    test_back_to_back();
    test_cursor_blink();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
